calc_chain_arbiter: RTL and testbench
=====================================

Name: calc_chain_arbiter

Overview:
Shares one divider→multiplier calculation chain between two requesters. Each cycle, at most one operand is granted into the chain's FIFO write port. A tag FIFO records which requester issued each operand. Each in-order chain result is routed back to the originating requester. Sits between the two operand producers and the chain top (write_req / fifo_write_data / full_out / done_sig / product).

Parameters:
DATA_W, 16, operand and result width
TAG_DEPTH, 8, max outstanding operations in flight (power of 2)
TAG_AW, 3, log2(TAG_DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operand
req0_data  in  DATA_W  requester 0 operand
req0_ready  out  1  requester 0 operand accepted this cycle (valid&&ready)
req1_valid  in  1  requester 1 has an operand
req1_data  in  DATA_W  requester 1 operand
req1_ready  out  1  requester 1 operand accepted this cycle
chain_write_req  out  1  write strobe into chain input FIFO
chain_write_data  out  DATA_W  operand to chain
chain_full  in  1  chain input FIFO full
chain_done  in  1  one-cycle pulse, chain result valid
chain_product  in  DATA_W  chain result
rsp0_valid  out  1  one-cycle pulse, result for requester 0
rsp1_valid  out  1  one-cycle pulse, result for requester 1
rsp_data  out  DATA_W  result data, valid when rsp0_valid or rsp1_valid
outstanding  out  TAG_AW+1  operations issued, result not yet returned
tag_err  out  1  sticky: chain_done with no outstanding tag

Behaviour:
- Reset (async, rst=1): all outputs 0; tag FIFO empty; rr pointer = requester 0; outstanding=0; tag_err=0.
- can_issue = !chain_full && (outstanding < TAG_DEPTH).
- Grant (combinational):
  - Only one valid → that requester wins.
  - Both valid → requester selected by rr pointer wins.
  - reqX_ready = can_issue && grant==X && reqX_valid. At most one ready per cycle.
- Issue, same cycle as accept (zero latency):
  - chain_write_req = req0_ready|req1_ready.
  - chain_write_data = granted data; 0 when no accept.
- On accept:
  - push requester id into tag FIFO;
  - rr pointer ← other requester (round-robin, updates only on accept).
- Blocked issue: chain_full=1 or tag FIFO full → no ready, no write_req. Pointer holds, so the waiting requester keeps priority.
- Return: chain_done=1 with outstanding>0:
  - pop tag FIFO head;
  - next cycle: rsp_data=chain_product (registered) and rspT_valid=1 for the popped tag T, for exactly 1 cycle.
  - rsp_data holds its last value otherwise.
- chain_done with outstanding==0: no pop, no rsp pulse, tag_err←1 (cleared only by rst).
- Same-cycle accept and chain_done: push and pop both occur; outstanding unchanged. Pop reads the old head, so no push/pop hazard even at count 0 (count 0 case → tag_err path).
- Tag FIFO: circular, TAG_AW-bit read/write pointers wrapping modulo TAG_DEPTH; full/empty from outstanding counter.
- Results return in issue order (chain is in-order FIFO); no reordering logic.
- Reset mid-operation: in-flight tags discarded. The chain shares rst and discards its contents too; no stale responses.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins when both valid; rr pointer logic removed.
- Undefined: round-robin as above.
- All other behaviour identical.

Test Plan:
- Reset then req0_valid=1 data=0x0010, chain idle → same cycle req0_ready=1, chain_write_req=1, chain_write_data=0x0010; outstanding=1 next cycle.
- Both valid continuously, data 0xA000/0xB000, chain never full → writes alternate 0xA000,0xB000,0xA000…; with ARB_FIXED_PRIO_EN only 0xA000.
- 8 accepts without chain_done → outstanding=8, both ready=0 though valid; one chain_done → outstanding=7, accept resumes next cycle.
- chain_full=1 for 5 cycles with req1_valid=1 → no ready/write_req; chain_full→0 → req1_ready=1 that cycle.
- Issue order r0,r1,r0; chain_done with 0x0001,0x0002,0x0003 → pulses rsp0(0x0001), rsp1(0x0002), rsp0(0x0003), each 1 cycle after its done.
- chain_done with outstanding=0 → tag_err=1 and stays 1; rst=1 asynchronously mid-burst → all outputs 0 immediately, outstanding=0.

Source files
------------

// File: rtl/calc_chain_arbiter_if.sv
// Requester, response and chain-side signals of calc_chain_arbiter.
// The arbiter takes the slave modport; the operand/chain side takes master.
interface calc_chain_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_AW = 3
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              chain_write_req;
  logic [DATA_W-1:0] chain_write_data;
  logic              chain_full;
  logic              chain_done;
  logic [DATA_W-1:0] chain_product;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_AW:0]   outstanding;
  logic              tag_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  chain_full, chain_done, chain_product,
    output req0_ready, req1_ready, chain_write_req, chain_write_data,
    output rsp0_valid, rsp1_valid, rsp_data, outstanding, tag_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output chain_full, chain_done, chain_product,
    input  req0_ready, req1_ready, chain_write_req, chain_write_data,
    input  rsp0_valid, rsp1_valid, rsp_data, outstanding, tag_err
  );
endinterface

// File: rtl/calc_chain_arbiter.sv
// Two-requester arbiter for a shared in-order divider->multiplier chain, with a tag FIFO
// routing results back. Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module calc_chain_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned TAG_AW    = 3
) (
  input logic                 clk,
  input logic                 rst,
  calc_chain_arbiter_if.slave bus
);
  localparam logic [TAG_AW:0] FullCount = (TAG_AW + 1)'(TAG_DEPTH);

  logic [TAG_AW:0]   r_outstanding;
  logic [TAG_AW-1:0] r_wr_ptr;
  logic [TAG_AW-1:0] r_rd_ptr;
  logic              r_tags [TAG_DEPTH];
  logic              r_rsp0;
  logic              r_rsp1;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_tag_err;

  logic w_can_issue;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_push;
  logic w_pop;
  logic w_head;

`ifdef ARB_FIXED_PRIO_EN
  always_comb w_grant1 = bus.req1_valid && !bus.req0_valid;
`else
  logic r_rr;

  always_comb w_grant1 = bus.req1_valid && (!bus.req0_valid || r_rr);

  // Pointer moves only on accept, so a blocked requester keeps its turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (w_push) begin
      r_rr <= w_acc0;
    end
  end
`endif

  // Reset gates issue so every output reads 0 while rst is held.
  always_comb begin
    w_can_issue = !rst && !bus.chain_full && (r_outstanding < FullCount);
    w_acc0      = w_can_issue && bus.req0_valid && !w_grant1;
    w_acc1      = w_can_issue && bus.req1_valid && w_grant1;
    w_push      = w_acc0 || w_acc1;
    w_pop       = bus.chain_done && (r_outstanding != '0);
    w_head      = r_tags[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= w_acc1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rsp0        <= 1'b0;
      r_rsp1        <= 1'b0;
      r_rsp_data    <= '0;
      r_tag_err     <= 1'b0;
    end else begin
      r_rsp0 <= w_pop && !w_head;
      r_rsp1 <= w_pop && w_head;
      if (w_pop) begin
        r_rsp_data <= bus.chain_product;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (bus.chain_done && (r_outstanding == '0)) begin
        r_tag_err <= 1'b1;
      end
      if (w_push && !w_pop) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (w_pop && !w_push) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
    end
  end

  assign bus.req0_ready       = w_acc0;
  assign bus.req1_ready       = w_acc1;
  assign bus.chain_write_req  = w_push;
  assign bus.chain_write_data = w_acc0 ? bus.req0_data : (w_acc1 ? bus.req1_data : '0);
  assign bus.rsp0_valid       = r_rsp0;
  assign bus.rsp1_valid       = r_rsp1;
  assign bus.rsp_data         = r_rsp_data;
  assign bus.outstanding      = r_outstanding;
  assign bus.tag_err          = r_tag_err;
endmodule

// File: tb/tb_calc_chain_arbiter.sv
// Self-checking bench for calc_chain_arbiter: directed steps plus random traffic,
// checked against a queue-based reference of the arbitration and tag routing rules.
module tb_calc_chain_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_chain_arbiter_if #(.DATA_W(16), .TAG_AW(3)) bus ();

  calc_chain_arbiter #(.DATA_W(16), .TAG_DEPTH(8), .TAG_AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: ids of issued-but-unanswered operands, oldest first.
  bit          m_q[$];
  bit          m_rr = 1'b0;
  bit          m_err = 1'b0;
  bit          e_rsp0 = 1'b0;
  bit          e_rsp1 = 1'b0;
  logic [15:0] e_data = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr   = 1'b0;
    m_err  = 1'b0;
    e_rsp0 = 1'b0;
    e_rsp1 = 1'b0;
    e_data = 16'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req0_ready"}, 32'(bus.req0_ready), 0);
    chk({tag, ".req1_ready"}, 32'(bus.req1_ready), 0);
    chk({tag, ".write_req"}, 32'(bus.chain_write_req), 0);
    chk({tag, ".write_data"}, 32'(bus.chain_write_data), 0);
    chk({tag, ".rsp0"}, 32'(bus.rsp0_valid), 0);
    chk({tag, ".rsp1"}, 32'(bus.rsp1_valid), 0);
    chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, ".outstanding"}, 32'(bus.outstanding), 0);
    chk({tag, ".tag_err"}, 32'(bus.tag_err), 0);
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit v0, input logic [15:0] d0, input bit v1, input logic [15:0] d1,
                     input bit full, input bit done, input logic [15:0] prod);
    bit can, g1, a0, a1, t;
    bus.req0_valid    = v0;
    bus.req0_data     = d0;
    bus.req1_valid    = v1;
    bus.req1_data     = d1;
    bus.chain_full    = full;
    bus.chain_done    = done;
    bus.chain_product = prod;
    #1;
    can = !full && (m_q.size() < 8);
`ifdef ARB_FIXED_PRIO_EN
    g1 = v1 && !v0;
`else
    g1 = v1 && (!v0 || m_rr);
`endif
    a0 = can && v0 && !g1;
    a1 = can && v1 && g1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(a0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(a1));
    chk("write_req", 32'(bus.chain_write_req), 32'(a0 | a1));
    chk("write_data", 32'(bus.chain_write_data), a0 ? 32'(d0) : (a1 ? 32'(d1) : 0));
    @(posedge clk);
    e_rsp0 = 1'b0;
    e_rsp1 = 1'b0;
    if (done) begin
      if (m_q.size() > 0) begin
        t      = m_q.pop_front();
        e_data = prod;
        e_rsp0 = !t;
        e_rsp1 = t;
      end else begin
        m_err = 1'b1;
      end
    end
    if (a0 || a1) begin
      m_q.push_back(a1);
      m_rr = a0;
    end
    #1;
    chk("outstanding", 32'(bus.outstanding), m_q.size());
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_rsp0));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_rsp1));
    chk("rsp_data", 32'(bus.rsp_data), 32'(e_data));
    chk("tag_err", 32'(bus.tag_err), 32'(m_err));
  endtask

  initial begin
    bus.req0_valid    = 1'b0;
    bus.req0_data     = '0;
    bus.req1_valid    = 1'b0;
    bus.req1_data     = '0;
    bus.chain_full    = 1'b0;
    bus.chain_done    = 1'b0;
    bus.chain_product = '0;
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single operand from requester 0 with an idle chain.
    cyc(1, 16'h0010, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h1234);

    // Both valid: alternation, then tag FIFO fills and blocks.
    for (int i = 0; i < 10; i++) cyc(1, 16'hA000, 1, 16'hB000, 0, 0, 16'h0);
    cyc(1, 16'hA000, 1, 16'hB000, 0, 1, 16'h5555);
    cyc(1, 16'hA000, 1, 16'hB000, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'(16'h0100 + i));

    // Chain full blocks requester 1 until it clears.
    for (int i = 0; i < 5; i++) cyc(0, 16'h0, 1, 16'hC001, 1, 0, 16'h0);
    cyc(0, 16'h0, 1, 16'hC001, 0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h0abc);

    // Issue r0, r1, r0 then in-order returns.
    cyc(1, 16'h0011, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 16'h0, 1, 16'h0022, 0, 0, 16'h0);
    cyc(1, 16'h0033, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h0001);
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h0002);
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h0003);
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);

    // Done with nothing outstanding, and accept+done in the same cycle at count 0.
    cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'hdead);
    cyc(1, 16'h0044, 0, 16'h0, 0, 1, 16'hbeef);
    cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0);

    // Asynchronous reset in the middle of a burst.
    cyc(1, 16'h0055, 1, 16'h0066, 0, 1, 16'h0777);
    cyc(1, 16'h0055, 1, 16'h0066, 0, 0, 16'h0);
    bus.chain_done = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit d;
      d = ($urandom_range(0, 2) == 0) && (m_q.size() > 0);
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
          $urandom_range(0, 3) == 0, d, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
